// File: rtl/instr_encoder.sv
// RV32I instruction encoder and instruction-memory loader: packs symbolic requests
// into machine words, buffers them in a FIFO and writes them sequentially from a base address.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t            state, next_state;
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] waddr;
  logic              fifo_full, fifo_empty, push, pop, finish, start_ok;
  logic              imm12_ok, b_ok, j_ok, shamt_ok, is_shift, legal;
  logic [31:0]       raw_word, word;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign busy       = (state != IDLE);
  assign in_ready   = (state == LOAD) && !fifo_full;
  assign push       = in_valid && in_ready;
  assign imem_we    = busy && !fifo_empty;
  assign pop        = imem_we && imem_ready;
  assign imem_addr  = waddr;
  assign imem_wdata = imem_we ? mem[rd_ptr] : '0;
  // A start coinciding with the done pulse belongs to the session that just ended.
  assign start_ok   = (state == IDLE) && start && !done;
  assign finish     = (state == DRAIN) && (fifo_empty || (count == CNT_W'(1) && pop));

  // Range checks: the immediate must be a sign-extension of its encodable field.
  assign imm12_ok = (in_imm[31:11] == {21{in_imm[11]}});
  assign b_ok     = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
  assign j_ok     = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
  assign shamt_ok = (in_imm[31:5] == '0);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  always_comb begin
    raw_word = NOP;
    legal    = 1'b0;
    case (in_kind)
      3'd0: begin
        raw_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        legal    = imm12_ok;
      end
      3'd1: begin
        raw_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        legal    = imm12_ok;
      end
      3'd2: begin
        raw_word = {1'b0, in_alt, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
        legal    = !in_alt || (in_funct3 == 3'b000) || (in_funct3 == 3'b101);
      end
      3'd3: begin
        raw_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                    in_imm[4:1], in_imm[11], 7'b1100011};
        legal    = b_ok;
      end
      3'd4: begin
        if (is_shift) begin
          raw_word = {1'b0, in_alt, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          legal    = shamt_ok && !(in_alt && in_funct3 == 3'b001);
        end else begin
          raw_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          legal    = imm12_ok && !in_alt;
        end
      end
      3'd5: begin
        raw_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        legal    = j_ok;
      end
      default: legal = 1'b0;
    endcase
    word = legal ? raw_word : NOP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = LOAD;
      LOAD:    if (push && in_last) next_state = DRAIN;
      DRAIN:   if (finish) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      waddr     <= '0;
      err_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (start_ok)  waddr <= base_addr & ~ADDR_W'(3);
      else if (pop)  waddr <= waddr + ADDR_W'(4);
      if (start_ok)
        err_count <= '0;
      else if (push && !legal && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  // NOTE: FIFO storage has no reset; imem_wdata is gated to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized sessions
// checked cycle by cycle against a behavioural scoreboard model.
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 16;

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [2:0]        in_kind = '0;
  logic [2:0]        in_funct3 = '0;
  logic              in_alt = 1'b0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready = 1'b0;
  logic              busy, done;
  logic [7:0]        err_count;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  req_t        reqs[$];
  logic [31:0] sb[$];
  wr_t         wr_log[$];
  int          occ = 0;
  int          m_err = 0;
  bit          loading = 0, draining = 0, exp_done = 0, last_push = 0;
  logic [15:0] exp_waddr = '0;

  int edges [0:19] = '{-1048578, -1048577, -1048576, 1048574, 1048575, 1048576,
                       -4098, -4097, -4096, 4094, 4095, 4096,
                       -2049, -2048, 2047, 2048, 31, 32, -1, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Encoding reference: legality from signed integer ranges, fields from the ISA layout.
  function automatic void ref_enc(input req_t r, output logic [31:0] w, output bit bad);
    int si;
    logic [31:0] u;
    si  = r.imm;
    u   = r.imm;
    bad = 1'b0;
    w   = 32'h13;
    case (r.kind)
      3'd0: begin
        bad = (si < -2048) || (si > 2047);
        w   = {u[11:0], r.rs1, 3'b010, r.rd, 7'h03};
      end
      3'd1: begin
        bad = (si < -2048) || (si > 2047);
        w   = {u[11:5], r.rs2, r.rs1, 3'b010, u[4:0], 7'h23};
      end
      3'd2: begin
        bad = r.alt && !(r.f3 == 3'd0 || r.f3 == 3'd5);
        w   = {1'b0, r.alt, 5'b0, r.rs2, r.rs1, r.f3, r.rd, 7'h33};
      end
      3'd3: begin
        bad = (si < -4096) || (si > 4094) || (si % 2 != 0);
        w   = {u[12], u[10:5], r.rs2, r.rs1, 3'b000, u[4:1], u[11], 7'h63};
      end
      3'd4: begin
        if (r.f3 == 3'd1 || r.f3 == 3'd5) begin
          bad = (si < 0) || (si > 31) || (r.alt && r.f3 == 3'd1);
          w   = {1'b0, r.alt, 5'b0, u[4:0], r.rs1, r.f3, r.rd, 7'h13};
        end else begin
          bad = (si < -2048) || (si > 2047) || r.alt;
          w   = {u[11:0], r.rs1, r.f3, r.rd, 7'h13};
        end
      end
      3'd5: begin
        bad = (si < -1048576) || (si > 1048574) || (si % 2 != 0);
        w   = {u[20], u[10:1], u[11], u[19:12], r.rd, 7'h6F};
      end
      default: bad = 1'b1;
    endcase
    if (bad) w = 32'h13;
  endfunction

  // Compares the current cycle's outputs with the model, then advances the model over the coming edge.
  task automatic monitor();
    bit idle_pre, done_pre, pop, push, bad;
    logic [31:0] w;
    req_t r;
    last_push = 0;
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_imem_we", imem_we, 0);
      check("rst_imem_addr", imem_addr, 0);
      check("rst_imem_wdata", imem_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err_count", err_count, 0);
      occ = 0; sb.delete(); loading = 0; draining = 0; exp_done = 0;
      m_err = 0; exp_waddr = '0;
      return;
    end
    idle_pre = !(loading || draining);
    done_pre = exp_done;
    check("busy", busy, !idle_pre);
    check("in_ready", in_ready, loading && occ < DEPTH);
    check("imem_we", imem_we, occ != 0);
    check("done", done, exp_done);
    check("err_count", err_count, m_err);
    if (imem_we && sb.size() > 0) begin
      check("imem_addr", imem_addr, exp_waddr);
      check("imem_wdata", imem_wdata, sb[0]);
    end
    pop  = imem_we && imem_ready;
    push = in_valid && in_ready;
    if (pop) begin
      wr_log.push_back('{addr: imem_addr, data: imem_wdata});
      if (sb.size() > 0) void'(sb.pop_front());
      exp_waddr = exp_waddr + 16'd4;
      occ--;
    end
    if (push) begin
      r = '{kind: in_kind, f3: in_funct3, alt: in_alt, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
      ref_enc(r, w, bad);
      sb.push_back(w);
      occ++;
      last_push = 1;
      if (bad && m_err < 255) m_err++;
      if (in_last) begin loading = 0; draining = 1; end
    end
    exp_done = 0;
    if (draining && occ == 0) begin exp_done = 1; draining = 0; end
    if (start && idle_pre && !done_pre) begin
      loading = 1; exp_waddr = base_addr & 16'hFFFC; m_err = 0;
    end
  endtask

  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  function automatic req_t mk(input int kind, input int f3, input int alt, input int rd,
                              input int rs1, input int rs2, input int imm);
    req_t r;
    r.kind = kind[2:0]; r.f3 = f3[2:0]; r.alt = alt[0];
    r.rd = rd[4:0]; r.rs1 = rs1[4:0]; r.rs2 = rs2[4:0]; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    int imm;
    case ($urandom_range(0, 5))
      0, 5: imm = int'($urandom_range(0, 80)) - 40;
      1, 2: imm = edges[$urandom_range(0, 19)];
      3:    imm = int'($urandom_range(0, 31));
      default: imm = int'($urandom());
    endcase
    return mk($urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
  endfunction

  task automatic begin_session(input logic [15:0] b);
    wr_log.delete();
    start = 1; base_addr = b;
    tick();
    start = 0;
  endtask

  // mode 0: always valid/ready; mode 1: random valid/ready. imem_ready is held low for the first stall cycles.
  task automatic send_reqs(input bit last, input int mode, input int stall, output int acc_stall);
    int i = 0;
    int c = 0;
    acc_stall = 0;
    while (i < reqs.size() && c < 2000) begin
      in_kind = reqs[i].kind; in_funct3 = reqs[i].f3; in_alt = reqs[i].alt;
      in_rd = reqs[i].rd; in_rs1 = reqs[i].rs1; in_rs2 = reqs[i].rs2; in_imm = reqs[i].imm;
      in_last    = last && (i == reqs.size() - 1);
      in_valid   = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      imem_ready = (c < stall) ? 1'b0 : ((mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0));
      tick();
      if (last_push) begin
        i++;
        if (c < stall) acc_stall++;
      end
      c++;
    end
    in_valid = 0; in_last = 0;
    check("send_budget", i, reqs.size());
  endtask

  task automatic wait_done(input int mode, input bit start_on_done);
    int c = 0;
    while (!done && c < 2000) begin
      imem_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      tick();
      c++;
    end
    check("done_seen", done, 1);
    if (start_on_done) begin start = 1; base_addr = 16'h0800; end
    tick();
    start = 0;
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int acc;
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    tick();

    // Two-word session from 0x0100
    reqs.delete();
    reqs.push_back(mk(0, 0, 0, 5, 2, 0, 8));
    reqs.push_back(mk(2, 0, 1, 3, 1, 2, 0));
    begin_session(16'h0100);
    send_reqs(1, 0, 0, acc);
    wait_done(0, 0);
    check("t1_n", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("t1_w0", wr_log[0].data, 32'h00812283);
      check("t1_a0", wr_log[0].addr, 16'h0100);
      check("t1_w1", wr_log[1].data, 32'h402081B3);
      check("t1_a1", wr_log[1].addr, 16'h0104);
    end
    check("t1_err", err_count, 0);

    // Branch and jump encodings; a start on the done cycle must be ignored
    reqs.delete();
    reqs.push_back(mk(3, 0, 0, 0, 1, 2, -4));
    reqs.push_back(mk(5, 0, 0, 1, 0, 0, 2048));
    begin_session(16'h0200);
    send_reqs(1, 0, 0, acc);
    wait_done(0, 1);
    check("t2_n", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("t2_beq", wr_log[0].data, 32'hFE208EE3);
      check("t2_jal", wr_log[1].data, 32'h001000EF);
    end

    // Illegal requests are replaced by NOP and counted
    reqs.delete();
    reqs.push_back(mk(3, 0, 0, 0, 1, 2, 3));
    reqs.push_back(mk(4, 0, 0, 1, 1, 0, 4096));
    reqs.push_back(mk(7, 0, 0, 1, 1, 1, 0));
    begin_session(16'h0300);
    send_reqs(1, 0, 0, acc);
    wait_done(0, 0);
    check("t3_n", wr_log.size(), 3);
    for (int k = 0; k < wr_log.size(); k++) check("t3_nop", wr_log[k].data, 32'h00000013);
    check("t3_err", err_count, 3);

    // Back-pressure: six requests with imem_ready low for twelve cycles
    reqs.delete();
    for (int k = 0; k < 6; k++) reqs.push_back(mk(4, 0, 0, k + 1, k, 0, 100 + k));
    begin_session(16'h0400);
    send_reqs(1, 0, 12, acc);
    check("t4_accepts_stalled", acc, DEPTH);
    wait_done(0, 0);
    check("t4_n", wr_log.size(), 6);

    // Address wrap
    reqs.delete();
    reqs.push_back(mk(0, 0, 0, 1, 2, 0, 4));
    reqs.push_back(mk(1, 0, 0, 0, 2, 3, -8));
    begin_session(16'hFFFE);
    send_reqs(1, 0, 0, acc);
    wait_done(0, 0);
    check("t5_n", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("t5_a0", wr_log[0].addr, 16'hFFFC);
      check("t5_a1", wr_log[1].addr, 16'h0000);
    end

    // Reset with three buffered words, then reload from a new base
    reqs.delete();
    for (int k = 0; k < 3; k++) reqs.push_back(mk(2, k, 0, k, k, k, 0));
    begin_session(16'h0500);
    send_reqs(0, 0, 10000, acc);
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    reqs.delete();
    reqs.push_back(mk(0, 0, 0, 7, 8, 0, -2048));
    reqs.push_back(mk(4, 5, 1, 9, 10, 0, 31));
    begin_session(16'h0340);
    send_reqs(1, 0, 0, acc);
    wait_done(0, 0);
    check("t6_n", wr_log.size(), 2);
    if (wr_log.size() == 2) check("t6_a0", wr_log[0].addr, 16'h0340);

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      int n = $urandom_range(1, 20);
      int mode = $urandom_range(0, 1);
      reqs.delete();
      for (int k = 0; k < n; k++) reqs.push_back(rand_req());
      begin_session(16'($urandom()));
      send_reqs(1, mode, $urandom_range(0, 6), acc);
      wait_done(mode, 0);
      check("rand_n", wr_log.size(), n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder and instruction-memory loader for the single-cycle core. It accepts symbolic instruction requests (kind, registers, signed immediate) over a valid/ready handshake and packs each into a 32-bit machine word, using the same six opcode classes the core's main decoder consumes. It buffers the words in a small FIFO and writes them sequentially into instruction memory from a base address. It runs before the core is released from reset, so test programs can be loaded without an external assembler.

## Interface
- DEPTH, 4: FIFO entries, power of two, ≥ 2.
- ADDR_W, 16: byte-address width of the imem write port.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a load session at base_addr.
- base_addr  in  ADDR_W  byte address of the first word; bits [1:0] ignored, treated as 0.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_last  in  1  marks the final request of the session.
- in_kind  in  3  0 LW, 1 SW, 2 R-ALU, 3 BEQ, 4 I-ALU, 5 JAL, 6–7 illegal.
- in_funct3  in  3  ALU funct3, used for R-ALU and I-ALU only.
- in_alt  in  1  sets instruction bit 30 (SUB/SRA/SRAI); R-ALU and I-ALU shifts only.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate or byte offset.
- imem_we  out  1  write request.
- imem_addr  out  ADDR_W  word-aligned byte address.
- imem_wdata  out  32  encoded word.
- imem_ready  in  1  write completes on a cycle with imem_we & imem_ready.
- busy  out  1  session active.
- done  out  1  one-cycle pulse after the last word is written.
- err_count  out  8  saturating count of substituted words.

## Operation
- FSM states: IDLE, LOAD, DRAIN.
  - IDLE: start goes to LOAD. The write pointer waddr is set to {base_addr[ADDR_W-1:2], 2'b00}, and err_count is cleared.
  - LOAD: in_ready = !fifo_full. Accepting a request with in_last goes to DRAIN.
  - DRAIN: in_ready = 0. When the FIFO is empty and no write is pending, done pulses and the FSM returns to IDLE.
- busy = (state != IDLE). start is ignored outside IDLE.
- Encoding is combinational on the accepted request; the encoded word is pushed into the FIFO on the same edge.
  - LW: {imm[11:0], rs1, 010, rd, 0000011}.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - R-ALU: {0, alt, 00000, rs2, rs1, funct3, rd, 0110011}. The alt bit is legal only for funct3 000 and 101; otherwise it is illegal.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
  - I-ALU, funct3 ≠ 001/101: {imm[11:0], rs1, funct3, rd, 0010011}. in_alt must be 0.
  - I-ALU, funct3 001/101 (shifts): {0, alt, 00000, imm[4:0], rs1, funct3, rd, 0010011}. Legal only when imm is 0..31, and alt = 0 when funct3 = 001.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
- Immediate range checks, with in_imm treated as signed:
  - LW, SW, I-ALU: −2048..2047.
  - BEQ: −4096..4094, and the value must be even.
  - JAL: −1048576..1048574, and the value must be even.
- Illegal kind, out-of-range immediate, misaligned offset or illegal alt: the word is replaced by NOP 32'h00000013 and err_count increments, saturating at 255.
- Writer:
  - imem_we = busy & !fifo_empty.
  - imem_addr = waddr, imem_wdata = FIFO head.
  - On imem_we & imem_ready the FIFO pops and waddr advances by 4, wrapping modulo 2^ADDR_W.

## Timing
- Reset values:
  - state IDLE, FIFO empty.
  - in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0.
  - busy 0, done 0, err_count 0.
- Reset asserted mid-session discards all buffered words at once. No write is issued after rst rises.
- Latency: a word accepted at edge N is presented on imem_we in cycle N+1 at the earliest.
- Full throughput is 1 word/cycle when imem_ready is held high.
- Push and pop on the same edge keep the occupancy unchanged.
- When the FIFO is full, in_ready is 0 even if a pop happens that cycle (no bypass).
- imem_addr and imem_wdata are held stable while imem_we & !imem_ready.
- done asserts in the cycle after the final write handshake. busy drops on the same edge as done is raised.
- A start pulse on the same cycle as done is ignored.

## Test plan
- base_addr 0x0100, imem_ready = 1. Send LW rd=5 rs1=2 imm=8, then R-ALU SUB rd=3 rs1=1 rs2=2 with in_last. Required: writes 0x00812283 @0x0100, then 0x402081B3 @0x0104; done one cycle after the second write; err_count 0.
- BEQ rs1=1 rs2=2 imm=−4 → 0xFE208EE3. JAL rd=1 imm=2048 → 0x001000EF.
- BEQ imm=3, then I-ALU imm=4096, then kind 7. Required: each writes 0x00000013; err_count = 3.
- Hold imem_ready = 0 while sending 6 requests with DEPTH=4. Required: in_ready falls after 4 accepts; imem_addr and imem_wdata stay stable; with imem_ready then held high, all 6 words are written in order.
- base_addr 0xFFFC, ADDR_W = 16, two words. Required: addresses 0xFFFC then 0x0000.
- Assert rst while 3 words are buffered. Required: imem_we goes low immediately; busy = 0; a new start then loads from the new base.
